icache_fetch: RTL and testbench

Parametrised instruction fetch unit for the RV32IC core: a direct-mapped instruction cache, predecode with static branch prediction, and a fetch queue feeding decode/issue. Sits between the memory controller and the instruction queue / LSB dispatch stage. It accepts redirects from branch/JALR resolution and supports whole-cache invalidation for FENCE.I.

---
 rtl/core_pkg.sv | 39 +++
 rtl/ifetch_predecode.sv | 30 +++
 rtl/icache_fetch.sv | 138 +++++++++++++
 tb/tb_icache_fetch.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: RV32/RVC fetch constants, immediate extraction and fetch-queue entry type.
package core_pkg;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;
  localparam logic [2:0] F3_CJAL  = 3'b001;
  localparam logic [2:0] F3_CJ    = 3'b101;
  localparam logic [2:0] F3_CBEQZ = 3'b110;
  localparam logic [2:0] F3_CBNEZ = 3'b111;
  localparam logic [2:0] F3_CJR   = 3'b100;

  typedef enum logic [1:0] {LOOKUP, MISS, DRAIN, HALT} fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        size;
    logic        taken;
    logic [31:0] pred_pc;
  } fetch_entry_t;

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_cj(input logic [31:0] i);
    return {{21{i[12]}}, i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
  endfunction

  function automatic logic [31:0] imm_cb(input logic [31:0] i);
    return {{24{i[12]}}, i[6:5], i[2], i[11:10], i[4:3], 1'b0};
  endfunction
endpackage

// File: rtl/ifetch_predecode.sv
// ifetch_predecode: combinational size/prediction/halt decode of one fetched instruction.
module ifetch_predecode import core_pkg::*; #(
  parameter bit BTFN = 1'b1
) (
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic        o_size,
  output logic        o_taken,
  output logic        o_halt,
  output logic [31:0] o_next_pc
);
  logic        w_rvc, w_jal, w_br, w_jalr, w_cj, w_cb, w_cjr;
  logic [2:0]  w_f3;
  logic [31:0] w_imm;
  always_comb begin
    w_rvc     = i_inst[1:0] != 2'b11;
    w_f3      = i_inst[15:13];
    w_jal     = !w_rvc && i_inst[6:0] == OP_JAL;
    w_br      = !w_rvc && i_inst[6:0] == OP_BRANCH;
    w_jalr    = !w_rvc && i_inst[6:0] == OP_JALR;
    w_cj      = i_inst[1:0] == Q1 && (w_f3 == F3_CJ || w_f3 == F3_CJAL);
    w_cb      = i_inst[1:0] == Q1 && (w_f3 == F3_CBEQZ || w_f3 == F3_CBNEZ);
    w_cjr     = i_inst[1:0] == Q2 && w_f3 == F3_CJR && i_inst[6:2] == 5'd0 && i_inst[11:7] != 5'd0;
    w_imm     = w_jal ? imm_j(i_inst) : w_br ? imm_b(i_inst) : w_cj ? imm_cj(i_inst) : imm_cb(i_inst);
    o_size    = !w_rvc;
    o_halt    = w_jalr || w_cjr;
    o_taken   = w_jal || w_cj || ((w_br || w_cb) && BTFN && w_imm[31]);
    o_next_pc = o_taken ? i_pc + w_imm : i_pc + (w_rvc ? 32'd2 : 32'd4);
  end
endmodule

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped icache, predecode with static prediction, and fetch queue.
module icache_fetch import core_pkg::*; #(
  parameter int          ENTRIES  = 32,
  parameter int          FQ_DEPTH = 4,
  parameter bit          BTFN     = 1'b1,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        fence_i,
  input  logic        stall,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_size,
  output logic        inst_pred_taken,
  output logic [31:0] inst_pred_pc
);
  localparam int IW = $clog2(ENTRIES);
  localparam int QW = $clog2(FQ_DEPTH);

  fetch_state_t  r_state;
  logic [31:0]   r_fetch_pc, r_mem_addr;
  logic          r_mem_req;
  logic [ENTRIES-1:0] r_valid;
  logic [31:0]   r_tag  [ENTRIES];
  logic [31:0]   r_data [ENTRIES];
  fetch_entry_t  r_q    [FQ_DEPTH];
  logic [QW-1:0] r_head, r_tail;
  logic [QW:0]   r_count;

  logic [IW-1:0] w_idx;
  logic          w_hit, w_full, w_pop, w_lookup, w_fill, w_push;
  logic          w_size, w_taken, w_halt;
  logic [31:0]   w_pd_inst, w_next_pc;
  fetch_entry_t  w_entry, w_head;

  // fence_i masks the hit so a same-cycle lookup already sees the invalidation
  assign w_idx     = r_fetch_pc[IW:1];
  assign w_hit     = r_valid[w_idx] && r_tag[w_idx] == r_fetch_pc && !fence_i;
  assign w_full    = r_count == (QW+1)'(FQ_DEPTH);
  assign w_pop     = inst_valid && inst_ready;
  assign w_lookup  = r_state == LOOKUP && !stall && !w_full && !redirect;
  assign w_fill    = r_state == MISS && mem_valid && !redirect;
  assign w_push    = w_fill || (w_lookup && w_hit);
  assign w_pd_inst = w_fill ? mem_data : r_data[w_idx];

  ifetch_predecode #(.BTFN(BTFN)) u_predecode (
    .i_inst    (w_pd_inst),
    .i_pc      (r_fetch_pc),
    .o_size    (w_size),
    .o_taken   (w_taken),
    .o_halt    (w_halt),
    .o_next_pc (w_next_pc)
  );

  assign w_entry = '{inst: w_pd_inst, pc: r_fetch_pc, size: w_size, taken: w_taken, pred_pc: w_next_pc};

  always_ff @(posedge clk)
    if (rst) begin
      r_state    <= LOOKUP;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_state    <= ((r_state == MISS || r_state == DRAIN) && !mem_valid) ? DRAIN : LOOKUP;
      if (mem_valid) r_mem_req <= 1'b0;
    end else begin
      case (r_state)
        LOOKUP:
          if (w_lookup && w_hit) begin
            r_fetch_pc <= w_next_pc;
            r_state    <= w_halt ? HALT : LOOKUP;
          end else if (w_lookup) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
            r_state    <= MISS;
          end
        MISS:
          if (mem_valid) begin
            r_mem_req  <= 1'b0;
            r_fetch_pc <= w_next_pc;
            r_state    <= w_halt ? HALT : LOOKUP;
          end
        DRAIN:
          if (mem_valid) begin
            r_mem_req <= 1'b0;
            r_state   <= LOOKUP;
          end
        default: ;
      endcase
    end

  always_ff @(posedge clk)
    if (rst) r_valid <= '0;
    else begin
      if (fence_i) r_valid <= '0;
      if (w_fill) r_valid[w_idx] <= 1'b1;
    end

  always_ff @(posedge clk)
    if (w_fill) begin
      r_tag[w_idx]  <= r_fetch_pc;
      r_data[w_idx] <= mem_data;
    end

  always_ff @(posedge clk)
    if (rst || redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (QW+1)'(w_push) - (QW+1)'(w_pop);
    end

  always_ff @(posedge clk)
    if (w_push) r_q[r_tail] <= w_entry;

  assign w_head          = inst_valid ? r_q[r_head] : '0;
  assign inst_valid      = r_count != '0;
  assign inst            = w_head.inst;
  assign inst_pc         = w_head.pc;
  assign inst_size       = w_head.size;
  assign inst_pred_taken = w_head.taken;
  assign inst_pred_pc    = w_head.pred_pc;
  assign mem_req         = r_mem_req;
  assign mem_addr        = r_mem_addr;
endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: directed checks of fetch, prediction, halt, redirect, queue-full and fence_i.
module tb_icache_fetch;
  logic        clk = 1'b0, rst = 1'b1, mem_valid = 1'b0, redirect = 1'b0;
  logic        fence_i = 1'b0, stall = 1'b0, inst_ready = 1'b0;
  logic [31:0] mem_data = '0, redirect_pc = '0;
  logic        mem_req, inst_valid, inst_size, inst_pred_taken;
  logic [31:0] mem_addr, inst, inst_pc, inst_pred_pc;
  logic        req0, valid0, size0, taken0;
  logic [31:0] addr0, inst0, pc0, ppc0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  icache_fetch #(.BTFN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_data(mem_data), .redirect(redirect), .redirect_pc(redirect_pc), .fence_i(fence_i),
    .stall(stall), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_size(inst_size), .inst_pred_taken(inst_pred_taken),
    .inst_pred_pc(inst_pred_pc)
  );

  icache_fetch #(.BTFN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_req(req0), .mem_addr(addr0), .mem_valid(mem_valid),
    .mem_data(mem_data), .redirect(redirect), .redirect_pc(redirect_pc), .fence_i(fence_i),
    .stall(stall), .inst_valid(valid0), .inst_ready(inst_ready), .inst(inst0),
    .inst_pc(pc0), .inst_size(size0), .inst_pred_taken(taken0), .inst_pred_pc(ppc0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_valid = 1'b0; redirect = 1'b0; fence_i = 1'b0; stall = 1'b0; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic serve(input logic [31:0] d, input int lat);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", mem_req, 1);
    repeat (lat - 1) @(negedge clk);
    mem_data = d;
    mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_ppc", inst_pred_pc, 0);
    chk("rst_size", inst_size, 0);
    chk("rst_taken", inst_pred_taken, 0);
    rst = 1'b0;

    serve(32'h00000013, 1);
    chk("cold_inst", inst, 32'h13);
    chk("cold_pc", inst_pc, 0);
    chk("cold_size", inst_size, 1);
    chk("cold_ppc", inst_pred_pc, 4);
    serve(32'h00000013, 1);
    serve(32'h00000013, 1);
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("cold_seq_pc", inst_pc, 4 * k);
      chk("cold_seq_ppc", inst_pred_pc, 4 * k + 4);
      @(negedge clk);
    end
    chk("cold_empty", inst_valid, 0);
    chk("cold_addr12", mem_addr, 12);
    redirect = 1'b1; redirect_pc = 32'h0; mem_valid = 1'b1; mem_data = 32'hDEADBEEF;
    @(negedge clk);
    redirect = 1'b0; mem_valid = 1'b0;
    chk("loop_req_drop", mem_req, 0);
    chk("loop_flush", inst_valid, 0);
    @(negedge clk);
    chk("loop_hit_valid", inst_valid, 1);
    chk("loop_hit_pc", inst_pc, 0);
    chk("loop_hit_noreq", mem_req, 0);
    @(negedge clk);
    chk("loop_hit4", inst_pc, 4);
    @(negedge clk);
    chk("loop_hit8", inst_pc, 8);
    @(negedge clk);
    chk("discard_req", mem_req, 1);
    chk("discard_addr", mem_addr, 12);

    do_reset();
    serve(32'hFE000EE3, 1);
    chk("btfn1_taken", inst_pred_taken, 1);
    chk("btfn1_ppc", inst_pred_pc, 32'hFFFFFFFC);
    chk("btfn0_taken", taken0, 0);
    chk("btfn0_ppc", ppc0, 4);
    @(negedge clk);
    chk("btfn1_next", mem_addr, 32'hFFFFFFFC);
    chk("btfn0_next", addr0, 4);

    do_reset();
    redirect = 1'b1; redirect_pc = 32'h10;
    @(negedge clk);
    redirect = 1'b0;
    serve(32'hA0010001, 1);
    chk("cnop_pc", inst_pc, 32'h10);
    chk("cnop_size", inst_size, 0);
    chk("cnop_taken", inst_pred_taken, 0);
    chk("cnop_ppc", inst_pred_pc, 32'h12);
    serve(32'h0000A001, 1);
    chk("cj_addr", mem_addr, 32'h12);
    inst_ready = 1'b1;
    @(negedge clk);
    chk("cj_pc", inst_pc, 32'h12);
    chk("cj_inst", inst, 32'h0000A001);
    chk("cj_size", inst_size, 0);
    chk("cj_taken", inst_pred_taken, 1);
    chk("cj_ppc", inst_pred_pc, 32'h12);
    @(negedge clk);
    chk("cj_rehit_valid", inst_valid, 1);
    chk("cj_rehit_pc", inst_pc, 32'h12);
    chk("cj_rehit_noreq", mem_req, 0);

    do_reset();
    serve(32'h00008067, 1);
    chk("jalr_pc", inst_pc, 0);
    chk("jalr_taken", inst_pred_taken, 0);
    chk("jalr_ppc", inst_pred_pc, 4);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= mem_req;
    end
    chk("halt_noreq", seen, 0);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    chk("halt_flush", inst_valid, 0);
    @(negedge clk);
    chk("halt_req", mem_req, 1);
    chk("halt_addr", mem_addr, 32'h100);

    do_reset();
    @(negedge clk);
    chk("drain_addr0", mem_addr, 0);
    redirect = 1'b1; redirect_pc = 32'h44;
    @(negedge clk);
    redirect = 1'b0;
    chk("drain_hold", mem_req, 1);
    @(negedge clk);
    mem_valid = 1'b1; mem_data = 32'h0000006F;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("drain_drop", mem_req, 0);
    chk("drain_nopush", inst_valid, 0);
    @(negedge clk);
    chk("drain_req", mem_req, 1);
    chk("drain_newaddr", mem_addr, 32'h44);
    serve(32'h00000013, 1);
    chk("drain_fill_pc", inst_pc, 32'h44);
    chk("drain_fill_ppc", inst_pred_pc, 32'h48);
    redirect = 1'b1; redirect_pc = 32'h0;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    chk("drain_nofill_req", mem_req, 1);
    chk("drain_nofill_addr", mem_addr, 0);

    do_reset();
    serve(32'h0000A001, 1);
    repeat (4) @(negedge clk);
    seen = 1'b0;
    repeat (8) begin
      seen |= mem_req;
      @(negedge clk);
    end
    chk("full_noreq", seen, 0);
    chk("full_head", inst_pc, 0);
    stall = 1'b1; inst_ready = 1'b1; n = 0;
    for (int k = 0; k < 10; k++) begin
      if (inst_valid) n++;
      @(negedge clk);
    end
    chk("full_count", n, 4);
    stall = 1'b0;
    @(negedge clk);
    chk("fence_prehit", inst_valid, 1);
    chk("fence_prenoreq", mem_req, 0);
    fence_i = 1'b1;
    @(negedge clk);
    fence_i = 1'b0;
    chk("fence_miss", mem_req, 1);
    chk("fence_addr", mem_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
